// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC and fetches one word per instruction over
// a req/ack instruction-memory handshake. It latches the word and presents it
// to the decoder together with its opcode/func fields, its address and the
// address plus four.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   imem_req, imem_addr        fetch request and word-aligned fetch address
//   imem_ack, imem_rdata       memory response; rdata is valid only with ack
//   stall                      hold the current instruction (hazard logic)
//   redirect, redirect_pc      load a new PC (branch/jump resolution)
//   inst_valid, inst           latched instruction; 0 (NOP) when not valid
//   opcode, func               inst[31:26] and inst[5:0]
//   inst_pc, pc_plus4          address of inst and that address + 4
module inst_fetch_unit #(
  parameter int unsigned             PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]     RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [PC_WIDTH-1:0] imem_rdata,
  input  logic                stall,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                inst_valid,
  output logic [PC_WIDTH-1:0] inst,
  output logic [5:0]          opcode,
  output logic [5:0]          func,
  output logic [PC_WIDTH-1:0] inst_pc,
  output logic [PC_WIDTH-1:0] pc_plus4
);

  typedef enum logic [1:0] {
    RST   = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    ISSUE = 2'd3
  } state_t;

  state_t              state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] target_q;
  logic [PC_WIDTH-1:0] ir_q;
  logic [PC_WIDTH-1:0] inst_pc_q;
  logic [PC_WIDTH-1:0] pc_plus4_q;
  logic                req_q;
  logic                valid_q;

  logic [PC_WIDTH-1:0] redir_tgt;
  logic [PC_WIDTH-1:0] drain_pc_d;
  logic                unused_rpc_lo;

  // Redirect targets are forced word aligned; the low bits are discarded.
  assign redir_tgt     = {redirect_pc[PC_WIDTH-1:2], 2'b00};
  assign unused_rpc_lo = ^redirect_pc[1:0];

  // A redirect arriving together with the draining ack is the newest target.
  always_comb begin
    drain_pc_d = target_q;
    if (redirect) drain_pc_d = redir_tgt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RST;
      pc_q       <= RESET_PC;
      target_q   <= '0;
      ir_q       <= '0;
      inst_pc_q  <= '0;
      pc_plus4_q <= '0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      case (state_q)
        RST: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            if (redirect) begin
              // Fetched word is on the wrong path: drop it and refetch.
              pc_q <= redir_tgt;
            end else begin
              ir_q       <= imem_rdata;
              inst_pc_q  <= pc_q;
              pc_plus4_q <= pc_q + PC_WIDTH'(4);
              pc_q       <= pc_q + PC_WIDTH'(4);
              state_q    <= ISSUE;
              req_q      <= 1'b0;
              valid_q    <= 1'b1;
            end
          end else if (redirect) begin
            // Request already in flight: keep it stable until it completes.
            target_q <= redir_tgt;
            state_q  <= DRAIN;
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            pc_q    <= drain_pc_d;
            state_q <= FETCH;
          end else if (redirect) begin
            target_q <= redir_tgt;
          end
        end
        ISSUE: begin
          if (!stall) begin
            if (redirect) pc_q <= redir_tgt;
            state_q <= FETCH;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= RST;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign inst_valid = valid_q;
  assign inst       = valid_q ? ir_q : '0;
  assign opcode     = inst[PC_WIDTH-1 -: 6];
  assign func       = inst[5:0];
  assign inst_pc    = inst_pc_q;
  assign pc_plus4   = pc_plus4_q;

endmodule
